// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers. Results are computed at launch
// and committed after a fixed 5-cycle (mult) or 10-cycle (div) busy window.
module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDOp,
  input  logic        MD_start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  logic [3:0]  r_cnt;
  logic [31:0] r_hi, r_lo, r_tmp_hi, r_tmp_lo;

  logic [3:0]  w_cnt_nxt;
  logic [31:0] w_hi_nxt, w_lo_nxt, w_tmp_hi_nxt, w_tmp_lo_nxt;

  logic        w_is_signed;
  logic [63:0] w_a_ext, w_b_ext, w_prod;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_abs, w_b_abs, w_b_div, w_q_u, w_r_u, w_quot, w_rem;

  // Operand conditioning plus the product and magnitude-based quotient/remainder.
  always_comb begin
    w_is_signed = (MDOp == OP_MULT) || (MDOp == OP_DIV);
    w_a_ext     = {(w_is_signed ? {32{A[31]}} : 32'h0), A};
    w_b_ext     = {(w_is_signed ? {32{B[31]}} : 32'h0), B};
    w_prod      = w_a_ext * w_b_ext;
    // Dividing magnitudes keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
    w_a_neg     = w_is_signed & A[31];
    w_b_neg     = w_is_signed & B[31];
    w_a_abs     = w_a_neg ? (32'h0 - A) : A;
    w_b_abs     = w_b_neg ? (32'h0 - B) : B;
    w_b_div     = (w_b_abs == 32'h0) ? 32'h1 : w_b_abs;
    w_q_u       = w_a_abs / w_b_div;
    w_r_u       = w_a_abs % w_b_div;
    w_quot      = (w_a_neg ^ w_b_neg) ? (32'h0 - w_q_u) : w_q_u;
    w_rem       = w_a_neg ? (32'h0 - w_r_u) : w_r_u;
  end

  // Next-state: count down and commit when busy, otherwise accept launches and moves.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_tmp_hi_nxt = r_tmp_hi;
    w_tmp_lo_nxt = r_tmp_lo;
    if (r_cnt != 4'd0) begin
      if (r_cnt == 4'd1) begin
        w_cnt_nxt = 4'd0;
        w_hi_nxt  = r_tmp_hi;
        w_lo_nxt  = r_tmp_lo;
      end else begin
        w_cnt_nxt = r_cnt - 4'd1;
      end
    end else begin
      case (MDOp)
        OP_MULT, OP_MULTU: begin
          if (MD_start) begin
            w_tmp_hi_nxt = w_prod[63:32];
            w_tmp_lo_nxt = w_prod[31:0];
            w_cnt_nxt    = MULT_CYCLES;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        OP_DIV, OP_DIVU: begin
          if (MD_start) begin
            // A zero divisor re-commits the current HI/LO so they appear unchanged.
            if (B == 32'h0) begin
              w_tmp_hi_nxt = r_hi;
              w_tmp_lo_nxt = r_lo;
            end else begin
              w_tmp_hi_nxt = w_rem;
              w_tmp_lo_nxt = w_quot;
            end
            w_cnt_nxt = DIV_CYCLES;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        OP_MTHI: w_hi_nxt = A;
        OP_MTLO: w_lo_nxt = A;
        default: w_cnt_nxt = r_cnt;
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 4'd0;
      r_hi     <= 32'h0;
      r_lo     <= 32'h0;
      r_tmp_hi <= 32'h0;
      r_tmp_lo <= 32'h0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_tmp_hi <= w_tmp_hi_nxt;
      r_tmp_lo <= w_tmp_lo_nxt;
    end
  end

  // Read port for mfhi/mflo.
  always_comb begin
    case (MDOp)
      OP_MFHI: MD_out = r_hi;
      OP_MFLO: MD_out = r_lo;
      default: MD_out = 32'h0;
    endcase
  end

  assign busy = (r_cnt != 4'd0);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: reset, mult/div results and latency,
// ignored requests, HI/LO moves, divide-by-zero, back-to-back and mid-op reset.
module tb_mdu;

  logic        clk;
  logic        reset;
  logic [3:0]  MDOp;
  logic        MD_start;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO, MD_out;

  int tests = 0;
  int fails = 0;

  mdu dut (
    .clk(clk), .reset(reset), .MDOp(MDOp), .MD_start(MD_start),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .MD_out(MD_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MDOp = 4'd0; MD_start = 1'b0; A = 32'h0; B = 32'h0;
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    MDOp = op; MD_start = 1'b1; A = a; B = b;
    tick();
    idle_inputs();
  endtask

  // Counts sampled busy cycles until busy falls; bounded so a stuck DUT cannot hang the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 30) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    MDOp = 4'd5;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (HI !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h expected 0", HI); end
    tests++; if (LO !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h expected 0", LO); end
    tests++; if (MD_out !== 32'h0) begin fails++; $display("FAIL reset_mdout: got %h expected 0", MD_out); end
    MDOp = 4'd0;
  endtask

  task automatic test_mult();
    int n;
    launch(4'd1, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    tests++; if (n !== 5) begin fails++; $display("FAIL mult_latency: got %0d expected 5", n); end
    tests++; if (HI !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi: got %h expected ffffffff", HI); end
    tests++; if (LO !== 32'hFFFFFFFA) begin fails++; $display("FAIL mult_lo: got %h expected fffffffa", LO); end
    launch(4'd2, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    tests++; if (n !== 5) begin fails++; $display("FAIL multu_latency: got %0d expected 5", n); end
    tests++; if (HI !== 32'h2) begin fails++; $display("FAIL multu_hi: got %h expected 2", HI); end
    tests++; if (LO !== 32'hFFFFFFFA) begin fails++; $display("FAIL multu_lo: got %h expected fffffffa", LO); end
  endtask

  task automatic test_div();
    int n;
    launch(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    tests++; if (n !== 10) begin fails++; $display("FAIL div_latency: got %0d expected 10", n); end
    tests++; if (LO !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_lo: got %h expected fffffffd", LO); end
    tests++; if (HI !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_hi: got %h expected ffffffff", HI); end
    launch(4'd4, 32'd7, 32'd2);
    wait_idle(n);
    tests++; if (LO !== 32'd3) begin fails++; $display("FAIL divu_lo: got %h expected 3", LO); end
    tests++; if (HI !== 32'd1) begin fails++; $display("FAIL divu_hi: got %h expected 1", HI); end
    launch(4'd3, 32'd7, 32'hFFFFFFFE);
    wait_idle(n);
    tests++; if (LO !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_negb_lo: got %h expected fffffffd", LO); end
    tests++; if (HI !== 32'd1) begin fails++; $display("FAIL div_negb_hi: got %h expected 1", HI); end
    launch(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    tests++; if (LO !== 32'h80000000) begin fails++; $display("FAIL div_ovf_lo: got %h expected 80000000", LO); end
    tests++; if (HI !== 32'h0) begin fails++; $display("FAIL div_ovf_hi: got %h expected 0", HI); end
  endtask

  task automatic test_ignore_busy();
    int n;
    launch(4'd1, 32'd6, 32'd7);
    MDOp = 4'd3; MD_start = 1'b1; A = 32'd100; B = 32'd3;
    tick();
    idle_inputs();
    wait_idle(n);
    tests++; if (n !== 4) begin fails++; $display("FAIL ignore_remaining: got %0d expected 4", n); end
    tests++; if (HI !== 32'h0) begin fails++; $display("FAIL ignore_hi: got %h expected 0", HI); end
    tests++; if (LO !== 32'd42) begin fails++; $display("FAIL ignore_lo: got %h expected 2a", LO); end
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignore_no_relaunch: got %b expected 0", busy); end
  endtask

  task automatic test_moves();
    int n;
    MDOp = 4'd7; A = 32'h1234;
    tick();
    MDOp = 4'd6; #1;
    tests++; if (MD_out !== 32'd42) begin fails++; $display("FAIL mflo_read: got %h expected 2a", MD_out); end
    MDOp = 4'd5; #1;
    tests++; if (MD_out !== 32'h1234) begin fails++; $display("FAIL mfhi_read: got %h expected 1234", MD_out); end
    MDOp = 4'd0; #1;
    tests++; if (MD_out !== 32'h0) begin fails++; $display("FAIL mdout_other: got %h expected 0", MD_out); end
    // A start strobe with a move opcode performs the move only.
    MDOp = 4'd7; MD_start = 1'b1; A = 32'd77;
    tick();
    idle_inputs();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL move_no_launch: got %b expected 0", busy); end
    tests++; if (HI !== 32'd77) begin fails++; $display("FAIL mthi_start: got %h expected 4d", HI); end
    launch(4'd2, 32'd2, 32'd3);
    MDOp = 4'd8; A = 32'hDEAD;
    tick();
    idle_inputs();
    wait_idle(n);
    tests++; if (LO !== 32'd6) begin fails++; $display("FAIL mtlo_busy_lo: got %h expected 6", LO); end
    tests++; if (HI !== 32'd0) begin fails++; $display("FAIL mtlo_busy_hi: got %h expected 0", HI); end
  endtask

  task automatic test_divzero();
    int n;
    MDOp = 4'd7; A = 32'd5; tick();
    MDOp = 4'd8; A = 32'd6; tick();
    idle_inputs();
    launch(4'd4, 32'd99, 32'd0);
    wait_idle(n);
    tests++; if (n !== 10) begin fails++; $display("FAIL divzero_latency: got %0d expected 10", n); end
    tests++; if (HI !== 32'd5) begin fails++; $display("FAIL divzero_hi: got %h expected 5", HI); end
    tests++; if (LO !== 32'd6) begin fails++; $display("FAIL divzero_lo: got %h expected 6", LO); end
    launch(4'd3, 32'hFFFFFF00, 32'd0);
    wait_idle(n);
    tests++; if (HI !== 32'd5 || LO !== 32'd6) begin fails++; $display("FAIL divzero_signed: got %h/%h expected 5/6", HI, LO); end
  endtask

  task automatic test_back_to_back();
    int n;
    launch(4'd1, 32'd3, 32'd4);
    MDOp = 4'd4; MD_start = 1'b1; A = 32'd20; B = 32'd3;
    wait_idle(n);
    tests++; if (n !== 5) begin fails++; $display("FAIL b2b_first_latency: got %0d expected 5", n); end
    tests++; if (LO !== 32'd12 || HI !== 32'd0) begin fails++; $display("FAIL b2b_first_result: got %h/%h expected 0/c", HI, LO); end
    tick();
    idle_inputs();
    wait_idle(n);
    tests++; if (n !== 10) begin fails++; $display("FAIL b2b_second_latency: got %0d expected 10", n); end
    tests++; if (LO !== 32'd6 || HI !== 32'd2) begin fails++; $display("FAIL b2b_second_result: got %h/%h expected 2/6", HI, LO); end
  endtask

  task automatic test_reset_mid();
    int n;
    launch(4'd3, 32'd100, 32'd7);
    tick();
    tick();
    reset = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    tests++; if (HI !== 32'h0 || LO !== 32'h0) begin fails++; $display("FAIL rstmid_hilo: got %h/%h expected 0/0", HI, LO); end
    #2;
    reset = 1'b0;
    #1;
    launch(4'd1, 32'd5, 32'd5);
    wait_idle(n);
    tests++; if (n !== 5) begin fails++; $display("FAIL rstmid_mult_latency: got %0d expected 5", n); end
    tests++; if (LO !== 32'd25 || HI !== 32'd0) begin fails++; $display("FAIL rstmid_mult_result: got %h/%h expected 0/19", HI, LO); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_mult();
    test_div();
    test_ignore_busy();
    test_moves();
    test_divzero();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have port `clk`, input, width 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port `reset`, input, width 1: asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port `MDOp`, input, width 4: operation code from the decoder. Encoding: else=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8.
REQ-004 SHALL have port `MD_start`, input, width 1: launch request, valid only together with MDOp of mult, multu, div or divu.
REQ-005 SHALL have port `A`, input, width 32: forwarded GRF[rs] operand.
REQ-006 SHALL have port `B`, input, width 32: forwarded GRF[rt] operand.
REQ-007 SHALL have port `busy`, output, width 1: a multi-cycle operation is in progress.
REQ-008 SHALL have port `HI`, output, width 32: architectural HI register.
REQ-009 SHALL have port `LO`, output, width 32: architectural LO register.
REQ-010 SHALL have port `MD_out`, output, width 32: read data for mfhi/mflo.

Function
REQ-011 SHALL hold internal state: HI, LO, a 4-bit down-counter `cnt`, and 32-bit pending registers `tmp_hi`/`tmp_lo`.
REQ-012 SHALL drive busy = (cnt != 0) combinationally from the counter.
REQ-013 SHALL, on an edge with MD_start=1, busy=0 and MDOp=mult/multu, compute the 64-bit product into tmp_hi/tmp_lo and load cnt=5.
- mult: signed product.
- multu: unsigned product.
REQ-014 SHALL, on an edge with MD_start=1, busy=0 and MDOp=div/divu, compute the division into tmp regs and load cnt=10.
- tmp_lo = quotient, truncated toward zero.
- tmp_hi = remainder, with the sign of the dividend.
- div: signed; divu: unsigned.
REQ-015 SHALL, while cnt>1, decrement cnt each edge; HI/LO unchanged.
REQ-016 SHALL, on the edge where cnt==1, set cnt=0 and commit HI=tmp_hi, LO=tmp_lo.
- Result: busy is high for exactly 5 (mult) or 10 (div) cycles after the launch edge.
- New HI/LO are visible in the first cycle busy is low.
REQ-017 SHALL ignore MD_start while busy=1: no relaunch, counter and tmp regs unaffected.
REQ-018 SHALL ignore MD_start when MDOp is not mult, multu, div or divu.
REQ-019 SHALL, on an edge with busy=0 and MDOp=mthi (mtlo), write HI=A (LO=A), independent of MD_start.
REQ-020 SHALL ignore mthi/mtlo while busy=1; upstream stall logic guarantees this does not occur.
REQ-021 SHALL drive MD_out combinationally: HI when MDOp=mfhi, LO when MDOp=mflo, else 32'h0.
- MD_out reflects the current registers regardless of busy.
REQ-022 SHALL leave HI/LO at their prior values when a div/divu with B==0 completes.
- Divide-by-zero still occupies busy for 10 cycles.
REQ-023 SHALL produce, for div with A=32'h80000000 and B=32'hFFFFFFFF, LO=32'h80000000 and HI=0.
REQ-024 SHALL give busy priority over new requests: a launch is accepted only on an edge where busy=0, including the edge on which the previous commit occurs.
REQ-025 SHALL expect the decoder's stall logic to stall D whenever (busy | MD_start) and the decoded instruction is an MD-class instruction; mdu itself provides no stall output beyond busy.

Reset
REQ-026 SHALL, while reset=1 (asynchronously), force HI=0, LO=0, cnt=0, tmp_hi=0 and tmp_lo=0.
- Outputs then read busy=0 and MD_out=0.
REQ-027 SHALL abandon any in-flight operation on reset mid-operation, with no HI/LO commit; the first post-reset edge accepts a new launch.

Verification
REQ-028 SHALL pass: mult with A=32'hFFFFFFFE, B=3 -> busy=1 for 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA; multu with same operands -> HI=2, LO=32'hFFFFFFFA.
REQ-029 SHALL pass: div with A=-7, B=2 -> busy=1 for 10 cycles, then LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; divu with A=7, B=2 -> LO=3, HI=1.
REQ-030 SHALL pass: mult launched, then MD_start with div at cycle 2 -> ignored; busy falls after cycle 5; HI/LO hold the mult result.
REQ-031 SHALL pass: mthi A=32'h1234 then mflo/mfhi -> MD_out=LO, then 32'h1234; mtlo while busy -> LO unchanged after commit.
REQ-032 SHALL pass: divu with B=0 and HI=5, LO=6 beforehand -> 10 busy cycles, then HI=5, LO=6.
REQ-033 SHALL pass: reset pulsed at busy cycle 3 of a div -> busy=0, HI=LO=0 immediately; mult launched next edge completes normally.
